// File: rtl/bf2_delay_stage.sv
// rtl/bf2_delay_stage.sv - radix-2 butterfly stage with delay buffer feeding fac8_1
module bf2_delay_stage #(
  parameter int I_WIDTH    = 10,
  parameter int O_WIDTH    = 11,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      din_valid,
  input  logic signed [I_WIDTH-1:0] din_re [DATA_WIDTH],
  input  logic signed [I_WIDTH-1:0] din_im [DATA_WIDTH],
  output logic                      dout_valid,
  output logic signed [O_WIDTH-1:0] dout_re [DATA_WIDTH],
  output logic signed [O_WIDTH-1:0] dout_im [DATA_WIDTH],
  output logic [2:0]                sel
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = O_WIDTH - I_WIDTH;

  // Frame position and drain sequencing
  logic [CW-1:0] icnt_q, icnt_d;
  logic [AW-1:0] dcnt_q, dcnt_d;
  logic          drain_active_q, drain_active_d;

  // Registered outputs
  logic                      dout_valid_q, dout_valid_d;
  logic [2:0]                sel_q, sel_d;
  logic signed [O_WIDTH-1:0] dout_re_q [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] dout_re_d [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] dout_im_q [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] dout_im_d [DATA_WIDTH];

  // Delay buffer: holds first-half rows, then the differences awaiting drain
  logic signed [O_WIDTH-1:0] mem_re_q [DEPTH][DATA_WIDTH];
  logic signed [O_WIDTH-1:0] mem_im_q [DEPTH][DATA_WIDTH];

  // Buffer write port
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic signed [O_WIDTH-1:0] wr_re [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] wr_im [DATA_WIDTH];

  // Decoded row role
  logic          is_fill;
  logic          is_pair;
  logic          last_pair;
  logic [AW-1:0] row;

  // Sign-extended input and the buffered partner row
  logic signed [O_WIDTH-1:0] ext_re [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] ext_im [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] a_re   [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] a_im   [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] dr_re  [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] dr_im  [DATA_WIDTH];

  // Classify the incoming row: lower half fills, upper half pairs with slot row
  always_comb begin
    row       = icnt_q[AW-1:0];
    is_fill   = din_valid & ~icnt_q[AW];
    is_pair   = din_valid &  icnt_q[AW];
    last_pair = is_pair && (row == AW'(DEPTH - 1));
  end

  // Operand fetch: pair read at slot row, drain read at slot dcnt (both see pre-write contents)
  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ext_re[i] = {{XW{din_re[i][I_WIDTH-1]}}, din_re[i]};
      ext_im[i] = {{XW{din_im[i][I_WIDTH-1]}}, din_im[i]};
      a_re[i]   = mem_re_q[row][i];
      a_im[i]   = mem_im_q[row][i];
      dr_re[i]  = mem_re_q[dcnt_q][i];
      dr_im[i]  = mem_im_q[dcnt_q][i];
    end
  end

  // Buffer write: raw sample during fill, a-b during pair, same slot index either way
  always_comb begin
    wr_en   = is_fill | is_pair;
    wr_addr = row;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      wr_re[i] = ext_re[i];
      wr_im[i] = ext_im[i];
      if (is_pair) begin
        wr_re[i] = a_re[i] - ext_re[i];
        wr_im[i] = a_im[i] - ext_im[i];
      end
    end
  end

  // Counter next-state: icnt steps on accepted rows, drain runs DEPTH cycles after the last pair
  always_comb begin
    icnt_d         = icnt_q;
    dcnt_d         = dcnt_q;
    drain_active_d = drain_active_q;
    if (din_valid) begin
      icnt_d = icnt_q + CW'(1);
    end
    if (drain_active_q) begin
      dcnt_d = dcnt_q + AW'(1);
      if (dcnt_q == AW'(DEPTH - 1)) begin
        drain_active_d = 1'b0;
      end
    end
    if (last_pair) begin
      drain_active_d = 1'b1;
      dcnt_d         = '0;
    end
  end

  // Output next-state: sums while pairing, buffered differences while draining, else hold
  always_comb begin
    dout_valid_d = 1'b0;
    sel_d        = sel_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      dout_re_d[i] = dout_re_q[i];
      dout_im_d[i] = dout_im_q[i];
    end
    if (is_pair) begin
      dout_valid_d = 1'b1;
      sel_d        = {row[1:0], 1'b0};
      for (int i = 0; i < DATA_WIDTH; i++) begin
        dout_re_d[i] = a_re[i] + ext_re[i];
        dout_im_d[i] = a_im[i] + ext_im[i];
      end
    end else if (drain_active_q) begin
      dout_valid_d = 1'b1;
      sel_d        = {dcnt_q[1:0], 1'b1};
      for (int i = 0; i < DATA_WIDTH; i++) begin
        dout_re_d[i] = dr_re[i];
        dout_im_d[i] = dr_im[i];
      end
    end
  end

  // Control and output registers; reset drops any partial frame
  always_ff @(posedge clk) begin
    if (!rstn) begin
      icnt_q         <= '0;
      dcnt_q         <= '0;
      drain_active_q <= 1'b0;
      dout_valid_q   <= 1'b0;
      sel_q          <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        dout_re_q[i] <= '0;
        dout_im_q[i] <= '0;
      end
    end else begin
      icnt_q         <= icnt_d;
      dcnt_q         <= dcnt_d;
      drain_active_q <= drain_active_d;
      dout_valid_q   <= dout_valid_d;
      sel_q          <= sel_d;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        dout_re_q[i] <= dout_re_d[i];
        dout_im_q[i] <= dout_im_d[i];
      end
    end
  end

  // Buffer storage; contents survive reset since every slot is rewritten before use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        mem_re_q[wr_addr][i] <= wr_re[i];
        mem_im_q[wr_addr][i] <= wr_im[i];
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign sel        = sel_q;
  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;

endmodule
